// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared writeback widths, arbiter states and requester ids
package regfile_wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  typedef enum logic {PRIO_MEM, PRIO_ALU} arb_state_e;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-write busy vector (issue set beats writeback clear) with sticky double-issue error
module wb_scoreboard
  import regfile_wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int NREG = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [NREG-1:0]   busy,
  output logic              sb_err
);
  logic [NREG-1:0] busy_q, busy_d, set_m, clr_m;
  logic err_q, err_d;
  always_comb begin
    set_m = {{(NREG-1){1'b0}}, set_en} << set_addr;
    clr_m = {{(NREG-1){1'b0}}, clr_en} << clr_addr;
    busy_d = (busy_q & ~clr_m) | set_m;
    err_d = err_q | (|(set_m & busy_q & ~clr_m));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign busy = busy_q;
  assign sb_err = err_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: ALU/MEM writeback arbiter with starvation guard and RAW scoreboard; REGFILE_WB_STATS_EN adds grant/stall counters
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_waddr,
  input  logic [DATA_W-1:0]    alu_wdata,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_waddr,
  input  logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_ready,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_waddr,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_din,
`ifdef REGFILE_WB_STATS_EN
  output logic [31:0]          stat_alu_grants,
  output logic [31:0]          stat_mem_grants,
  output logic [31:0]          stat_alu_stalls,
`endif
  output logic [2**ADDR_W-1:0] busy,
  output logic                 sb_err
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  arb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, we_d, alu_gnt, mem_gnt, gnt_id;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] din_q, din_d;
  always_comb begin
    mem_gnt = !rst && mem_valid && (state_q == PRIO_MEM || !alu_valid);
    alu_gnt = !rst && alu_valid && !mem_gnt;
    gnt_id = mem_gnt ? REQ_MEM : REQ_ALU;
    we_d = alu_gnt || mem_gnt;
    waddr_d = !we_d ? waddr_q : gnt_id == REQ_MEM ? mem_waddr : alu_waddr;
    din_d = !we_d ? din_q : gnt_id == REQ_MEM ? mem_wdata : alu_wdata;
    cnt_d = (!alu_valid || alu_gnt) ? '0 : cnt_q == CNT_W'(STARVE_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    state_d = state_q == PRIO_MEM ? (cnt_d == CNT_W'(STARVE_MAX) ? PRIO_ALU : PRIO_MEM)
                                  : ((alu_gnt || !alu_valid) ? PRIO_MEM : PRIO_ALU);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIO_MEM;
      cnt_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      din_q <= din_d;
    end
  end
  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;
  assign rf_we = we_q;
  assign rf_waddr = waddr_q;
  assign rf_din = din_q;
  wb_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(issue_valid),
    .set_addr(issue_waddr),
    .clr_en(we_d),
    .clr_addr(waddr_d),
    .busy(busy),
    .sb_err(sb_err)
  );
`ifdef REGFILE_WB_STATS_EN
  logic [31:0] ag_q, ag_d, mg_q, mg_d, st_q, st_d;
  always_comb begin
    ag_d = ag_q + {31'd0, alu_gnt};
    mg_d = mg_q + {31'd0, mem_gnt};
    st_d = st_q + {31'd0, alu_valid && !alu_gnt && st_q != '1};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ag_q <= '0;
      mg_q <= '0;
      st_q <= '0;
    end else begin
      ag_q <= ag_d;
      mg_q <= mg_d;
      st_q <= st_d;
    end
  end
  assign stat_alu_grants = ag_q;
  assign stat_mem_grants = mg_q;
  assign stat_alu_stalls = st_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven directed bench plus double-issue and mid-operation reset sequences
module tb_regfile_wb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic alu_valid, mem_valid, issue_valid, alu_ready, mem_ready, rf_we, sb_err;
  logic [4:0] alu_waddr, mem_waddr, issue_waddr, rf_waddr;
  logic [31:0] alu_wdata, mem_wdata, rf_din, busy;
  int tests = 0, fails = 0;
`ifdef REGFILE_WB_STATS_EN
  logic [31:0] s_ag, s_mg, s_st;
`endif
  regfile_wb_arbiter dut (
    .clk(clk),
    .rst(rst),
    .alu_valid(alu_valid),
    .alu_waddr(alu_waddr),
    .alu_wdata(alu_wdata),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .issue_valid(issue_valid),
    .issue_waddr(issue_waddr),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_din(rf_din),
`ifdef REGFILE_WB_STATS_EN
    .stat_alu_grants(s_ag),
    .stat_mem_grants(s_mg),
    .stat_alu_stalls(s_st),
`endif
    .busy(busy),
    .sb_err(sb_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic iv; logic [4:0] ia;
    logic e_ar, e_mr, e_we; logic [4:0] e_wa; logic [31:0] e_din, e_busy; logic e_err;
  } vec_t;
  vec_t tv[22];
  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic iv, input logic [4:0] ia,
                              input logic ear, input logic emr, input logic ewe, input logic [4:0] ewa,
                              input logic [31:0] edin, input logic [31:0] ebusy, input logic eerr);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md; v.iv = iv; v.ia = ia;
    v.e_ar = ear; v.e_mr = emr; v.e_we = ewe; v.e_wa = ewa; v.e_din = edin; v.e_busy = ebusy; v.e_err = eerr;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic iv, input logic [4:0] ia);
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    mem_valid = mv; mem_waddr = ma; mem_wdata = md;
    issue_valid = iv; issue_waddr = ia;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tv[i] = mk(0,0,0, 0,0,0, 0,0, 0,0,0,5'd0,32'h0,32'h0,0);
    tv[5]  = mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 1,0,1,5'd5,32'hDEADBEEF,32'h0,0);
    tv[6]  = mk(0,0,0, 0,0,0, 0,0, 0,0,0,5'd5,32'hDEADBEEF,32'h0,0);
    tv[7]  = mk(1,1,32'h11111111, 1,2,32'h2222, 0,0, 0,1,1,5'd2,32'h2222,32'h0,0);
    tv[8]  = mk(1,1,32'h11111111, 1,3,32'h3333, 0,0, 0,1,1,5'd3,32'h3333,32'h0,0);
    tv[9]  = mk(1,1,32'h11111111, 1,4,32'h4444, 0,0, 0,1,1,5'd4,32'h4444,32'h0,0);
    tv[10] = mk(1,1,32'h11111111, 1,6,32'h6666, 0,0, 1,0,1,5'd1,32'h11111111,32'h0,0);
    tv[11] = mk(0,0,0, 1,6,32'h6666, 0,0, 0,1,1,5'd6,32'h6666,32'h0,0);
    tv[12] = mk(0,0,0, 0,0,0, 0,0, 0,0,0,5'd6,32'h6666,32'h0,0);
    tv[13] = mk(0,0,0, 0,0,0, 1,7, 0,0,0,5'd6,32'h6666,32'h80,0);
    tv[14] = mk(1,7,32'h77, 0,0,0, 0,0, 1,0,1,5'd7,32'h77,32'h0,0);
    tv[15] = mk(0,0,0, 0,0,0, 1,7, 0,0,0,5'd7,32'h77,32'h80,0);
    tv[16] = mk(1,7,32'h78, 0,0,0, 1,7, 1,0,1,5'd7,32'h78,32'h80,0);
    tv[17] = mk(1,7,32'h79, 0,0,0, 0,0, 1,0,1,5'd7,32'h79,32'h0,0);
    tv[18] = mk(0,0,0, 0,0,0, 1,31, 0,0,0,5'd7,32'h79,32'h80000000,0);
    tv[19] = mk(0,0,0, 1,31,32'h1F1F, 0,0, 0,1,1,5'd31,32'h1F1F,32'h0,0);
    tv[20] = mk(1,10,32'h0000AAAA, 1,10,32'hAAAA0000, 0,0, 0,1,1,5'd10,32'hAAAA0000,32'h0,0);
    tv[21] = mk(1,10,32'h0000AAAA, 0,0,0, 0,0, 1,0,1,5'd10,32'h0000AAAA,32'h0,0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tv[i].av, tv[i].aa, tv[i].ad, tv[i].mv, tv[i].ma, tv[i].md, tv[i].iv, tv[i].ia);
      #1;
      chk($sformatf("v%0d alu_ready", i), {31'd0, alu_ready}, {31'd0, tv[i].e_ar});
      chk($sformatf("v%0d mem_ready", i), {31'd0, mem_ready}, {31'd0, tv[i].e_mr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rf_we", i), {31'd0, rf_we}, {31'd0, tv[i].e_we});
      chk($sformatf("v%0d rf_waddr", i), {27'd0, rf_waddr}, {27'd0, tv[i].e_wa});
      chk($sformatf("v%0d rf_din", i), rf_din, tv[i].e_din);
      chk($sformatf("v%0d busy", i), busy, tv[i].e_busy);
      chk($sformatf("v%0d sb_err", i), {31'd0, sb_err}, {31'd0, tv[i].e_err});
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    @(posedge clk); #1;
    chk("dbl first busy", busy, 32'h200);
    chk("dbl first err", {31'd0, sb_err}, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    @(posedge clk); #1;
    chk("dbl second busy", busy, 32'h200);
    chk("dbl second err", {31'd0, sb_err}, 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 1, 9, 32'h99, 0, 0);
    #1;
    chk("dbl wb mem_ready", {31'd0, mem_ready}, 32'd1);
    @(posedge clk); #1;
    chk("dbl wb busy", busy, 32'h0);
    chk("dbl wb rf_din", rf_din, 32'h99);
    chk("dbl wb err sticky", {31'd0, sb_err}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk($sformatf("dbl idle%0d err", i), {31'd0, sb_err}, 32'd1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 12);
    @(posedge clk); #1;
    chk("rst pre busy", busy, 32'h1000);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 1, 3, 32'h5555, 0, 0);
    #1;
    chk("rst mem_ready", {31'd0, mem_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rst rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst rf_din", rf_din, 32'd0);
    chk("rst busy", busy, 32'd0);
    chk("rst sb_err", {31'd0, sb_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("post rst rf_we", {31'd0, rf_we}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback requesters: ALU and MEM (load return).
- Each requester uses a valid/ready handshake; the block drives the register file's we/waddr/din through registered outputs.
- Keeps a pending-write scoreboard, set by the issue stage and cleared on writeback grant, so issue logic can detect RAW hazards.
- Sits between the execute/memory stages and register_file, next to issue control.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width; register count NREG = 2**ADDR_W.
- STARVE_MAX, 3, consecutive cycles ALU may wait while MEM wins before ALU is forced to win.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU writeback request.
- alu_waddr  in  ADDR_W  ALU destination register.
- alu_wdata  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request granted this cycle (combinational).
- mem_valid  in  1  MEM writeback request.
- mem_waddr  in  ADDR_W  MEM destination register.
- mem_wdata  in  DATA_W  MEM load data.
- mem_ready  out  1  MEM request granted this cycle (combinational).
- issue_valid  in  1  an instruction writing issue_waddr was issued.
- issue_waddr  in  ADDR_W  destination of the issued instruction.
- rf_we  out  1  to register_file we (registered).
- rf_waddr  out  ADDR_W  to register_file waddr (registered).
- rf_din  out  DATA_W  to register_file din (registered).
- busy  out  NREG  scoreboard; bit i=1 means register i has a pending write.
- sb_err  out  1  sticky flag: issue to an already-busy register.

Behaviour:
- Reset, with rst=1 at posedge: rf_we=0, rf_waddr=0, rf_din=0, busy=0, sb_err=0, starve counter=0, FSM=PRIO_MEM.
- Handshake:
  - A transfer occurs when valid && ready.
  - A requester holds valid, waddr and wdata stable until ready.
  - At most one ready is high per cycle.
  - ready is never high without the matching valid.
- FSM PRIO_MEM (default):
  - mem_valid → grant MEM.
  - Else alu_valid → grant ALU.
- FSM PRIO_ALU:
  - alu_valid → grant ALU.
  - Else mem_valid → grant MEM.
- Starve counter (width clog2(STARVE_MAX+1)):
  - Increments when alu_valid && !alu_ready.
  - Clears on ALU grant or when !alu_valid.
  - Saturates at STARVE_MAX.
- FSM transitions:
  - When the counter reaches STARVE_MAX, go to PRIO_ALU next cycle.
  - Return to PRIO_MEM after one ALU grant, or when alu_valid drops.
- Write latency: a grant at cycle N gives rf_we=1, rf_waddr and rf_din equal to the granted pair at cycle N+1. Throughput is one write per cycle.
- Idle cycle (no grant):
  - rf_we=0.
  - rf_waddr and rf_din hold the last committed pair.
  - Required because register_file bypasses din whenever raddr==waddr regardless of we. Holding the last committed pair keeps the bypass value equal to the stored value.
- Scoreboard:
  - issue_valid sets busy[issue_waddr] at the next edge.
  - A grant clears busy[granted waddr] at the next edge. The data is visible through the register_file bypass in the same cycle rf_we is high.
  - Set and clear of the same register in the same cycle: set wins, because the issue is the newer writer.
  - issue_valid to a register already busy and not being cleared that cycle: set sb_err=1, held until rst. busy stays 1.
- Same-address requests from ALU and MEM in one cycle: no merging. Each write commits in grant order.
- Reset mid-operation: in-flight handshakes are dropped. Requesters must deassert valid during rst; ready=0 while rst=1.

Optional Feature:
- Macro: REGFILE_WB_STATS_EN.
- When defined, adds three outputs, each 32-bit and cleared on rst:
  - stat_alu_grants: ALU grant count, wrapping.
  - stat_mem_grants: MEM grant count, wrapping.
  - stat_alu_stalls: cycles with alu_valid && !alu_ready, saturating at 0xFFFFFFFF.
- When undefined, the ports and counters are absent. Function is otherwise identical.

Decomposition:
- Package regfile_wb_pkg holds:
  - DATA_W and ADDR_W defaults.
  - FSM state enum {PRIO_MEM, PRIO_ALU}.
  - Requester-id constants REQ_ALU=0, REQ_MEM=1.
- Sub-module wb_scoreboard (busy vector, set/clear priority, sb_err) is natural.
- Arbiter FSM, starve counter and output registers stay in the top module.

Test Plan:
- Reset then idle: after rst, rf_we=0, rf_waddr=0, rf_din=0, busy=0, sb_err=0; outputs stay unchanged for 5 idle cycles.
- Single ALU write: alu_valid, waddr=5, wdata=0xDEADBEEF at cycle N → alu_ready=1 at N; rf_we=1, rf_waddr=5, rf_din=0xDEADBEEF at N+1; rf_we=0 at N+2 with addr and data held.
- Contention/starvation, STARVE_MAX=3: ALU (waddr 1) and MEM (waddrs 2,3,4,6) both continuously valid → MEM granted 3 cycles, ALU granted on cycle 4, MEM resumes cycle 5.
- Scoreboard: issue_valid waddr=7 → busy[7]=1 next cycle. ALU write to 7 granted → busy[7]=0 after the grant edge. Issue to 7 and grant of 7 in the same cycle → busy[7]=1.
- Double issue: issue waddr=9 twice without a writeback → sb_err=1 and stays 1 until rst.
- Mid-operation reset: rst asserted during a MEM grant → mem_ready=0, and on the next cycle rf_we=0 and busy=0.
